// File: rtl/wish_pkg.sv
// Shared types for the Wishbone burst initiators: FSM state encoding and bus word size.
package wish_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      FINISH
   } wbr_state_t;

   localparam int unsigned WORD_BYTES = 2;

endpackage

// File: rtl/wish_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and synchronous flush.
module wish_sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // A full FIFO still accepts a push when the same cycle frees a slot.
   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != (AW+1)'(DEPTH)) || do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= wr_data;
   end

   assign rd_data = mem[rd_ptr];
   assign empty   = (count == '0);

endmodule

// File: rtl/wish_burst_reader.sv
// Wishbone read initiator: fetches len_i consecutive 16-bit words, one transfer at a time,
// and streams them out through a first-word-fall-through FIFO.
module wish_burst_reader
   import wish_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int TIMEOUT    = 1024,
   parameter int LEN_W      = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [31:0]      base_i,
   input  logic [LEN_W-1:0] len_i,
   input  logic             abort_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   output logic             m_cyc_o,
   output logic             m_stb_o,
   output logic             m_we_o,
   output logic             m_sel_o,
   output logic [31:0]      m_adr_o,
   input  logic [15:0]      m_dat_i,
   input  logic             m_ack_i,
   output logic             out_valid_o,
   output logic [15:0]      out_data_o,
   input  logic             out_ready_i
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   wbr_state_t       state_q;
   wbr_state_t       state_nxt;
   logic [31:0]      adr_q;
   logic [LEN_W-1:0] rem_q;
   logic [TMO_W-1:0] tmo_q;
   logic             err_q;
   logic             latch;
   logic             push;
   logic             fin_err;
   logic             pop;
   logic             fifo_empty;
   logic [15:0]      fifo_data;
   logic [CNT_W-1:0] fifo_count;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_nxt;
   end

   // Abort wins over a coincident ack, so that word is never pushed.
   always_comb begin
      state_nxt = state_q;
      latch     = 1'b0;
      push      = 1'b0;
      fin_err   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               if (len_i != '0) begin
                  latch     = 1'b1;
                  state_nxt = ISSUE;
               end else begin
                  state_nxt = FINISH;
               end
            end
         end
         ISSUE: begin
            if (abort_i)                                state_nxt = FINISH;
            else if (fifo_count < CNT_W'(FIFO_DEPTH))   state_nxt = WAIT;
         end
         WAIT: begin
            if (abort_i) begin
               state_nxt = FINISH;
            end else if (m_ack_i) begin
               push      = 1'b1;
               state_nxt = (rem_q == LEN_W'(1)) ? FINISH : ISSUE;
            end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
               state_nxt = FINISH;
               fin_err   = 1'b1;
            end
         end
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         adr_q <= '0;
         rem_q <= '0;
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         if (latch) begin
            adr_q <= base_i & ~32'h1;
            rem_q <= len_i;
         end else if (push) begin
            adr_q <= adr_q + 32'(WORD_BYTES);
            rem_q <= rem_q - LEN_W'(1);
         end
         if (state_q == ISSUE)     tmo_q <= '0;
         else if (state_q == WAIT) tmo_q <= tmo_q + TMO_W'(1);
         if (state_nxt == FINISH)  err_q <= fin_err;
      end
   end

   wish_sync_fifo #(
      .WIDTH (16),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk_i),
      .rst     (rst_i),
      .flush   (abort_i),
      .push    (push),
      .wr_data (m_dat_i),
      .pop     (pop),
      .rd_data (fifo_data),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign pop         = out_valid_o && out_ready_i;
   assign out_valid_o = !fifo_empty;
   assign out_data_o  = fifo_empty ? '0 : fifo_data;

   assign busy_o  = (state_q == ISSUE) || (state_q == WAIT);
   assign done_o  = (state_q == FINISH);
   assign err_o   = err_q;
   assign m_cyc_o = (state_q == WAIT);
   assign m_stb_o = (state_q == WAIT);
   assign m_we_o  = 1'b0;
   assign m_sel_o = 1'b1;
   assign m_adr_o = adr_q;

endmodule
